// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if: request/grant/credit bundle between one router output and its arbiter
interface output_port_arbiter_if #(
    parameter int N_PORTS   = 5,
    parameter int N_BIT_SEL = 3,
    parameter int CREDIT_W  = 3
);
    logic [N_PORTS-1:0]   req;
    logic [N_PORTS-1:0]   tail;
    logic                 credit_in;
    logic [N_PORTS-1:0]   grant;
    logic [N_BIT_SEL-1:0] select;
    logic                 fire;
    logic [CREDIT_W-1:0]  credit_cnt;
    logic                 busy;
    logic                 timeout;
    modport master (
        output req, tail, credit_in,
        input  grant, select, fire, credit_cnt, busy, timeout
    );
    modport slave (
        input  req, tail, credit_in,
        output grant, select, fire, credit_cnt, busy, timeout
    );
endinterface

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter with credit gating; ARB_WATCHDOG_EN adds a stall watchdog
module output_port_arbiter #(
    parameter int N_PORTS   = 5,
    parameter int N_BIT_SEL = 3,
    parameter int CREDITS   = 4,
    parameter int CREDIT_W  = 3,
    parameter int TIMEOUT   = 16
) (
    input logic                  clk,
    input logic                  rst,
    output_port_arbiter_if.slave io_arb
);
    localparam logic [N_BIT_SEL-1:0] IN_NON = N_BIT_SEL'(N_PORTS);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t               r_state;
    logic [N_PORTS-1:0]   r_grant;
    logic [N_BIT_SEL-1:0] r_select, r_ptr, w_win;
    logic [CREDIT_W-1:0]  r_credit;
    logic                 r_timeout, w_fire, w_tail, w_expire;
    // Scan from farthest to nearest so the port right after r_ptr wins last.
    always_comb begin
        w_win = r_ptr;
        for (int k = N_PORTS; k >= 1; k--) begin
            if (io_arb.req[N_BIT_SEL'((int'(r_ptr) + k) % N_PORTS)]) w_win = N_BIT_SEL'((int'(r_ptr) + k) % N_PORTS);
        end
    end
    assign w_fire = !rst && r_state == LOCKED && |(io_arb.req & r_grant) && r_credit != '0;
    assign w_tail = |(io_arb.tail & r_grant);
`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wd;
    assign w_expire = r_state == LOCKED && !w_fire && r_wd == WD_W'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) r_wd <= '0;
        else r_wd <= (r_state == IDLE || w_fire || w_expire) ? '0 : r_wd + 1'b1;
    end
`else
    assign w_expire = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_select  <= IN_NON;
            r_ptr     <= N_BIT_SEL'(N_PORTS - 1);
            r_credit  <= CREDIT_W'(CREDITS);
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_fire && !io_arb.credit_in) r_credit <= r_credit - 1'b1;
            else if (!w_fire && io_arb.credit_in && r_credit != CREDIT_W'(CREDITS)) r_credit <= r_credit + 1'b1;
            if (r_state == IDLE) begin
                if (|io_arb.req) begin
                    r_state  <= LOCKED;
                    r_grant  <= N_PORTS'(1) << w_win;
                    r_select <= w_win;
                end
            end else if ((w_fire && w_tail) || w_expire) begin
                r_state  <= IDLE;
                r_grant  <= '0;
                r_select <= IN_NON;
                r_ptr    <= r_select;
            end
        end
    end
    assign io_arb.grant      = r_grant;
    assign io_arb.select     = r_select;
    assign io_arb.fire       = w_fire;
    assign io_arb.credit_cnt = r_credit;
    assign io_arb.busy       = r_state == LOCKED;
    assign io_arb.timeout    = r_timeout;
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed table, corner sequences and random traffic against a packet-level model
module tb_output_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    output_port_arbiter_if ifc ();
    output_port_arbiter dut (.clk(clk), .rst(rst), .io_arb(ifc));
    int n_tests = 0;
    int n_fail  = 0;
    int m_owner, m_ptr, m_cred, m_wd;
    bit m_to;
    typedef struct {
        bit         r;
        logic [4:0] q, t;
        bit         c;
        logic [4:0] g;
        logic [2:0] s;
        bit         f;
        logic [2:0] cr;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_fire(input bit r, input logic [4:0] q);
        return !r && m_owner >= 0 && q[m_owner] && m_cred > 0;
    endfunction

    task automatic model_step(input bit r, input logic [4:0] q, input logic [4:0] t, input bit c);
        bit f;
        int idx;
        f = m_fire(r, q);
        if (r) begin
            m_owner = -1; m_ptr = 4; m_cred = 4; m_wd = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (f && !c) m_cred--;
        else if (!f && c && m_cred < 4) m_cred++;
        if (m_owner < 0) begin
            for (int k = 1; k <= 5; k++) begin
                idx = (m_ptr + k) % 5;
                if (q[idx]) begin
                    m_owner = idx;
                    break;
                end
            end
        end else if (f && t[m_owner]) begin
            m_ptr = m_owner; m_owner = -1; m_wd = 0;
        end else begin
`ifdef ARB_WATCHDOG_EN
            m_wd = f ? 0 : m_wd + 1;
            if (m_wd == 16) begin
                m_ptr = m_owner; m_owner = -1; m_wd = 0; m_to = 1;
            end
`endif
        end
    endtask

    task automatic cycle(input bit r, input logic [4:0] q, input logic [4:0] t, input bit c);
        @(negedge clk);
        rst = r; ifc.req = q; ifc.tail = t; ifc.credit_in = c;
        #1;
        chk("grant", ifc.grant, m_owner < 0 ? 0 : 32'(5'b1 << m_owner));
        chk("select", ifc.select, m_owner < 0 ? 5 : m_owner);
        chk("fire", ifc.fire, m_fire(r, q));
        chk("credit_cnt", ifc.credit_cnt, m_cred);
        chk("busy", ifc.busy, m_owner >= 0);
        chk("timeout", ifc.timeout, m_to);
        model_step(r, q, t, c);
    endtask

    initial begin
        int seen;
        logic [4:0] rq;
        rst = 1'b1; ifc.req = '0; ifc.tail = '0; ifc.credit_in = 1'b0;
        repeat (2) @(posedge clk);
        model_step(1'b1, 5'b0, 5'b0, 1'b0);
        // reset state held with no traffic
        for (int i = 0; i < 10; i++) begin
            cycle(0, 5'b0, 5'b0, 0);
            chk("idle_select", ifc.select, 5);
            chk("idle_credit", ifc.credit_cnt, 4);
        end
        tbl[0]  = '{0, 5'b00100, 5'b00100, 0, 5'b00000, 3'd5, 0, 3'd4};
        tbl[1]  = '{0, 5'b00100, 5'b00100, 0, 5'b00100, 3'd2, 1, 3'd4};
        tbl[2]  = '{0, 5'b00000, 5'b00000, 0, 5'b00000, 3'd5, 0, 3'd3};
        tbl[3]  = '{0, 5'b00000, 5'b00000, 1, 5'b00000, 3'd5, 0, 3'd3};
        tbl[4]  = '{0, 5'b00000, 5'b00000, 0, 5'b00000, 3'd5, 0, 3'd4};
        tbl[5]  = '{1, 5'b00000, 5'b00000, 0, 5'b00000, 3'd5, 0, 3'd4};
        tbl[6]  = '{0, 5'b11111, 5'b11111, 1, 5'b00000, 3'd5, 0, 3'd4};
        tbl[7]  = '{0, 5'b11111, 5'b11111, 1, 5'b00001, 3'd0, 1, 3'd4};
        tbl[8]  = '{0, 5'b11111, 5'b11111, 1, 5'b00000, 3'd5, 0, 3'd4};
        tbl[9]  = '{0, 5'b11111, 5'b11111, 1, 5'b00010, 3'd1, 1, 3'd4};
        tbl[10] = '{0, 5'b11111, 5'b11111, 1, 5'b00000, 3'd5, 0, 3'd4};
        tbl[11] = '{0, 5'b11111, 5'b11111, 1, 5'b00100, 3'd2, 1, 3'd4};
        tbl[12] = '{0, 5'b11111, 5'b11111, 1, 5'b00000, 3'd5, 0, 3'd4};
        tbl[13] = '{0, 5'b11111, 5'b11111, 1, 5'b01000, 3'd3, 1, 3'd4};
        tbl[14] = '{0, 5'b11111, 5'b11111, 1, 5'b00000, 3'd5, 0, 3'd4};
        tbl[15] = '{0, 5'b11111, 5'b11111, 1, 5'b10000, 3'd4, 1, 3'd4};
        tbl[16] = '{0, 5'b11111, 5'b11111, 1, 5'b00000, 3'd5, 0, 3'd4};
        tbl[17] = '{0, 5'b11111, 5'b11111, 1, 5'b00001, 3'd0, 1, 3'd4};
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].r, tbl[i].q, tbl[i].t, tbl[i].c);
            chk($sformatf("tbl%0d_grant", i), ifc.grant, tbl[i].g);
            chk($sformatf("tbl%0d_select", i), ifc.select, tbl[i].s);
            chk($sformatf("tbl%0d_fire", i), ifc.fire, tbl[i].f);
            chk($sformatf("tbl%0d_credit", i), ifc.credit_cnt, tbl[i].cr);
        end
        // 6-flit packet from port 1 with no returning credits
        cycle(1, 5'b0, 5'b0, 0);
        cycle(0, 5'b00010, 5'b0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 5'b00010, 5'b0, 0);
            chk("c4_fire", ifc.fire, 1);
        end
        cycle(0, 5'b00010, 5'b0, 0);
        chk("c4_stall_fire", ifc.fire, 0);
        chk("c4_stall_busy", ifc.busy, 1);
        chk("c4_stall_cred", ifc.credit_cnt, 0);
        cycle(0, 5'b00010, 5'b0, 1);
        cycle(0, 5'b00010, 5'b0, 0);
        chk("c4_fire5", ifc.fire, 1);
        cycle(0, 5'b00010, 5'b00010, 0);
        chk("c4_tail_wait", ifc.fire, 0);
        cycle(0, 5'b00010, 5'b00010, 1);
        chk("c4_tail_wait2", ifc.fire, 0);
        cycle(0, 5'b00010, 5'b00010, 0);
        chk("c4_tail_fire", ifc.fire, 1);
        cycle(0, 5'b0, 5'b0, 0);
        chk("c4_released", ifc.busy, 0);
        // owner 3 bubbles while port 0 waits
        cycle(1, 5'b0, 5'b0, 0);
        cycle(0, 5'b01000, 5'b0, 0);
        cycle(0, 5'b01000, 5'b0, 0);
        cycle(0, 5'b01000, 5'b0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 5'b00001, 5'b0, 0);
            chk("c5_hold_grant", ifc.grant, 5'b01000);
            chk("c5_hold_fire", ifc.fire, 0);
        end
        cycle(0, 5'b01001, 5'b0, 1);
        chk("c5_resume", ifc.fire, 1);
        cycle(0, 5'b01001, 5'b01000, 0);
        chk("c5_cred_same", ifc.credit_cnt, 2);
        cycle(0, 5'b00001, 5'b0, 0);
        cycle(0, 5'b00001, 5'b00001, 0);
        chk("c5_next_owner", ifc.grant, 5'b00001);
        // owner 4 stalls indefinitely
        cycle(1, 5'b0, 5'b0, 0);
        cycle(0, 5'b10000, 5'b0, 0);
        cycle(0, 5'b10000, 5'b0, 0);
`ifdef ARB_WATCHDOG_EN
        seen = -1;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            cycle(0, 5'b00001, 5'b0, 0);
            if (ifc.timeout) seen = i;
        end
        chk("wd_cycle", seen, 16);
        chk("wd_busy", ifc.busy, 0);
        cycle(0, 5'b00001, 5'b0, 0);
        chk("wd_next_owner", ifc.grant, 5'b00001);
`else
        for (int i = 0; i < 100; i++) cycle(0, 5'b00001, 5'b0, 0);
        chk("lock_busy", ifc.busy, 1);
        chk("lock_grant", ifc.grant, 5'b10000);
        chk("lock_timeout", ifc.timeout, 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            rq = 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 199) == 0, rq, rq & 5'($urandom) & 5'($urandom), $urandom_range(0, 2) == 0);
        end
        seen = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
